// File: rtl/bsg_sipo_dbuf_pkg.sv
// Shared types and helpers for the double-buffered serial-in/parallel-out assembler.
package bsg_sipo_dbuf_pkg;

    typedef enum logic [1:0] {
        eEmpty,
        eFilling,
        eFull
    } bank_state_e;

    function automatic int unsigned safe_clog2(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // A zero or oversized request means "use the whole vector".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned els);
        return ((len == 0) || (len > els)) ? els : len;
    endfunction

endpackage

// File: rtl/bsg_sipo_dbuf_bank.sv
// One storage bank of the double-buffered SIPO: element array, beat counter, latched length, state.
// Optional BSG_SIPO_DBUF_ZERO_FILL_EN clears the whole array on the first beat of a vector.
//
// state    | meaning
// eEmpty   | no vector held; next write is the first beat of a new vector
// eFilling | vector partially written; count_q beats accepted so far
// eFull    | vector complete and waiting for the consumer
module bsg_sipo_dbuf_bank
    import bsg_sipo_dbuf_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int els_p       = 4,
    parameter int lg_els_p    = 2,
    parameter int len_width_p = 3
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           we_i,
    input  logic                           first_i,
    input  logic                           last_i,
    input  logic                           yumi_i,
    input  logic [lg_els_p-1:0]            idx_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [len_width_p-1:0]         len_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [lg_els_p-1:0]            count_o,
    output logic [len_width_p-1:0]         len_o,
    output logic [els_p-1:0][width_p-1:0]  data_o
);

    bank_state_e                  state_q, state_d;
    logic [lg_els_p-1:0]          count_q, count_d;
    logic [len_width_p-1:0]       len_q, len_d;
    logic [els_p-1:0][width_p-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            eEmpty, eFilling: begin
                if (we_i) begin
                    if (first_i) begin
                        len_d = len_i;
                    end
                    if (last_i) begin
                        state_d = eFull;
                        count_d = '0;
                    end else begin
                        state_d = eFilling;
                        count_d = count_q + 1'b1;
                    end
                end
            end
            eFull: begin
                if (yumi_i) begin
                    state_d = eEmpty;
                end
            end
            default: state_d = eEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eEmpty;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        data_d = data_q;
`ifdef BSG_SIPO_DBUF_ZERO_FILL_EN
        if (first_i) begin
            data_d = '0;
        end
`endif
        data_d[idx_i] = data_i;
    end

    // Storage is deliberately left out of reset; consumers only look at it while full.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            data_q <= data_d;
        end
    end

    assign full_o  = (state_q == eFull);
    assign empty_o = (state_q == eEmpty);
    assign count_o = count_q;
    assign len_o   = len_q;
    assign data_o  = data_q;

endmodule

// File: rtl/bsg_serial_in_parallel_out_dbuf.sv
// Double-buffered SIPO: fills one bank from narrow beats while the other is presented as a wide word.
// Define BSG_SIPO_DBUF_ZERO_FILL_EN to zero unused elements of each vector.
module bsg_serial_in_parallel_out_dbuf
    import bsg_sipo_dbuf_pkg::*;
#(
    parameter  int width_p        = 8,
    parameter  int els_p          = 4,
    parameter  int msb_then_lsb_p = 0,
    localparam int lg_els_lp      = safe_clog2(els_p),
    localparam int len_width_lp   = safe_clog2(els_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  logic [width_p-1:0]            data_i,
    input  logic [len_width_lp-1:0]       len_i,
    output logic                          v_o,
    output logic [els_p-1:0][width_p-1:0] data_o,
    output logic [len_width_lp-1:0]       len_o,
    input  logic                          yumi_i
);

    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    logic rdy_en_q;

    logic [1:0]                                full, empty, we, yumi_bank;
    logic [1:0][lg_els_lp-1:0]                 count;
    logic [1:0][len_width_lp-1:0]              bank_len;
    logic [1:0][els_p-1:0][width_p-1:0]        bank_data;

    logic                    fill_full, fill_empty, accept, last, yumi_take;
    logic [lg_els_lp-1:0]    fill_count, idx;
    logic [len_width_lp-1:0] fill_len, len_clamped, len_eff, count_ext;

    assign fill_full   = full[wr_ptr_q];
    assign fill_empty  = empty[wr_ptr_q];
    assign fill_count  = count[wr_ptr_q];
    assign fill_len    = bank_len[wr_ptr_q];
    assign len_clamped = len_width_lp'(clamp_len(32'(len_i), els_p));

    // The first beat has not latched a length yet, so it uses the incoming one directly.
    assign len_eff   = fill_empty ? len_clamped : fill_len;
    assign count_ext = len_width_lp'(fill_count);
    assign last      = (count_ext == (len_eff - len_width_lp'(1)));

    always_comb begin
        idx = fill_count;
        if (msb_then_lsb_p != 0) begin
            idx = lg_els_lp'(len_eff - len_width_lp'(1) - count_ext);
        end
    end

    // rdy_en_q keeps ready_o low through reset and the edge that releases it.
    assign ready_o   = rdy_en_q & ~fill_full;
    assign accept    = v_i & ready_o;
    assign v_o       = full[rd_ptr_q];
    assign yumi_take = yumi_i & v_o;

    assign we[0]        = accept & ~wr_ptr_q;
    assign we[1]        = accept &  wr_ptr_q;
    assign yumi_bank[0] = yumi_take & ~rd_ptr_q;
    assign yumi_bank[1] = yumi_take &  rd_ptr_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bsg_sipo_dbuf_bank #(
            .width_p     (width_p),
            .els_p       (els_p),
            .lg_els_p    (lg_els_lp),
            .len_width_p (len_width_lp)
        ) u_bank (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .we_i      (we[b]),
            .first_i   (fill_empty),
            .last_i    (last),
            .yumi_i    (yumi_bank[b]),
            .idx_i     (idx),
            .data_i    (data_i),
            .len_i     (len_clamped),
            .full_o    (full[b]),
            .empty_o   (empty[b]),
            .count_o   (count[b]),
            .len_o     (bank_len[b]),
            .data_o    (bank_data[b])
        );
    end

    assign wr_ptr_d = wr_ptr_q ^ (accept & last);
    assign rd_ptr_d = rd_ptr_q ^ yumi_take;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign data_o = bank_data[rd_ptr_q];
    assign len_o  = bank_len[rd_ptr_q];

`ifndef SYNTHESIS
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_dbuf.sv
// Bench for the double-buffered SIPO: lsb-first and msb-first instances share stimulus.
module tb_bsg_serial_in_parallel_out_dbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, v, yumi;
    logic [7:0]  din;
    logic [2:0]  len;
    logic        ready0, vo0, ready1, vo1;
    logic [31:0] dout0, dout1;
    logic [2:0]  leno0, leno1;

    bsg_serial_in_parallel_out_dbuf #(.width_p(8), .els_p(4), .msb_then_lsb_p(0)) dut_lsb (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready0), .data_i(din), .len_i(len),
        .v_o(vo0), .data_o(dout0), .len_o(leno0), .yumi_i(yumi));

    bsg_serial_in_parallel_out_dbuf #(.width_p(8), .els_p(4), .msb_then_lsb_p(1)) dut_msb (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready1), .data_i(din), .len_i(len),
        .v_o(vo1), .data_o(dout1), .len_o(leno1), .yumi_i(yumi));

    typedef struct packed {
        logic [2:0]  len;
        logic [31:0] beats;
    } vec_t;

    typedef struct packed {
        logic [2:0]  len_in;
        logic [31:0] beats;
        logic [2:0]  nbeats;
        logic [2:0]  exp_len;
        logic [31:0] exp_lsb;
        logic [31:0] exp_msb;
        logic [31:0] exp_mask;
    } tv_t;

    vec_t        q[$];
    logic [7:0]  part[$];
    int unsigned cur_len;
    bit          rdy_en;
    bit          last_acc;
    int          n_popped;
    int          n_checks = 0;
    int          n_fail   = 0;
    tv_t         tv[6];

    function automatic logic [31:0] exp_word(input vec_t x, input bit msb);
        logic [31:0] w;
        int idx;
        w = '0;
        for (int i = 0; i < int'(x.len); i++) begin
            idx = msb ? int'(x.len) - 1 - i : i;
            w[idx*8 +: 8] = x.beats[i*8 +: 8];
        end
        return w;
    endfunction

    function automatic logic [31:0] len_mask(input logic [2:0] l);
        return (l >= 3'd4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * l)) - 32'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit acc, tk;
        logic [7:0] d;
        logic [2:0] l;
        vec_t nv;
        logic [31:0] m;
        acc = v && rdy_en && (q.size() < 2);
        tk  = yumi && (q.size() > 0);
        d = din;
        l = len;
        @(posedge clk);
        #1;
        if (reset_n) rdy_en = 1'b1;
        if (tk) begin
            void'(q.pop_front());
            n_popped++;
        end
        if (acc) begin
            if (part.size() == 0) cur_len = (l == 0 || l > 4) ? 4 : int'(l);
            part.push_back(d);
            if (part.size() == cur_len) begin
                nv = '0;
                nv.len = 3'(cur_len);
                for (int i = 0; i < part.size(); i++) nv.beats[i*8 +: 8] = part[i];
                q.push_back(nv);
                part.delete();
            end
        end
        last_acc = acc;
        check("v_o_lsb",     vo0,    q.size() > 0);
        check("v_o_msb",     vo1,    q.size() > 0);
        check("ready_o_lsb", ready0, rdy_en && (q.size() < 2));
        check("ready_o_msb", ready1, rdy_en && (q.size() < 2));
        if (q.size() > 0) begin
            m = len_mask(q[0].len);
            check("len_o_lsb",  leno0, q[0].len);
            check("len_o_msb",  leno1, q[0].len);
            check("data_o_lsb", dout0 & m, exp_word(q[0], 1'b0));
            check("data_o_msb", dout1 & m, exp_word(q[0], 1'b1));
`ifdef BSG_SIPO_DBUF_ZERO_FILL_EN
            check("zero_fill_lsb", dout0 & ~m, 32'd0);
            check("zero_fill_msb", dout1 & ~m, 32'd0);
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            yumi = 1'b1;
            step();
        end
        yumi = 1'b0;
        check("drain_v_o", vo0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, ncyc, nlow, pop0;

        tv[0] = '{3'd4, 32'h44332211, 3'd4, 3'd4, 32'h44332211, 32'h11223344, 32'hFFFFFFFF};
        tv[1] = '{3'd3, 32'h00A3A2A1, 3'd3, 3'd3, 32'h00A3A2A1, 32'h00A1A2A3, 32'h00FFFFFF};
        tv[2] = '{3'd0, 32'h04030201, 3'd4, 3'd4, 32'h04030201, 32'h01020304, 32'hFFFFFFFF};
        tv[3] = '{3'd7, 32'h8D7C6B5A, 3'd4, 3'd4, 32'h8D7C6B5A, 32'h5A6B7C8D, 32'hFFFFFFFF};
        tv[4] = '{3'd1, 32'h000000EE, 3'd1, 3'd1, 32'h000000EE, 32'h000000EE, 32'h000000FF};
        tv[5] = '{3'd2, 32'h00003412, 3'd2, 3'd2, 32'h00003412, 32'h00001234, 32'h0000FFFF};

        reset_n = 1'b0; v = 1'b0; yumi = 1'b0; din = '0; len = '0;
        rdy_en = 1'b0; n_popped = 0; cur_len = 4; last_acc = 1'b0;
        #1;
        check("reset_ready", ready0, 1'b0);
        check("reset_v_o",   vo0,    1'b0);
        check("reset_len_o", leno0,  3'd0);
        check("reset_v_o_msb", vo1,  1'b0);
        #11;
        reset_n = 1'b1;
        step();

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < int'(tv[t].nbeats); k++) begin
                v = 1'b1; len = tv[t].len_in; din = tv[t].beats[k*8 +: 8];
                step();
            end
            v = 1'b0;
            check("tv_v_o",     vo0,   1'b1);
            check("tv_len_o",   leno0, tv[t].exp_len);
            check("tv_data_lsb", dout0 & tv[t].exp_mask, tv[t].exp_lsb);
            check("tv_data_msb", dout1 & tv[t].exp_mask, tv[t].exp_msb);
`ifdef BSG_SIPO_DBUF_ZERO_FILL_EN
            check("tv_zero_lsb", dout0 & ~tv[t].exp_mask, 32'd0);
`endif
            yumi = 1'b1;
            step();
            yumi = 1'b0;
        end

        // Backpressure: both banks fill with no consumer.
        v = 1'b1; len = 3'd4; nacc = 0; ncyc = 0;
        while (nacc < 8 && ncyc < 40) begin
            din = 8'($urandom); step();
            if (last_acc) nacc++;
            ncyc++;
        end
        check("bp_accepted", nacc, 8);
        check("bp_ready_low", ready0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            din = 8'($urandom); step();
            check("bp_ready_held", ready0, 1'b0);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        check("bp_ready_back", ready0, 1'b1);
        while (nacc < 12 && ncyc < 80) begin
            din = 8'($urandom); step();
            if (last_acc) nacc++;
            ncyc++;
        end
        check("bp_total", nacc, 12);
        v = 1'b0;
        drain();

        // Throughput: len 1, consumer always takes.
        v = 1'b1; len = 3'd1; nacc = 0; nlow = 0; pop0 = n_popped;
        for (int i = 0; i < 64; i++) begin
            din = 8'($urandom);
            yumi = (q.size() > 0);
            step();
            if (last_acc) nacc++;
            if (!ready0) nlow++;
        end
        v = 1'b0;
        drain();
        check("tp_accepted", nacc, 64);
        check("tp_ready_drops", nlow, 0);
        check("tp_vectors", n_popped - pop0, 64);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            din  = 8'($urandom);
            len  = 3'($urandom_range(0, 7));
            yumi = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            step();
        end
        v = 1'b0;
        yumi = 1'b0;
        drain();
        for (int i = 0; i < 4 && part.size() > 0; i++) begin
            v = 1'b1; din = 8'($urandom); step();
        end
        v = 1'b0;
        drain();

        // Asynchronous reset with one full and one partial vector held.
        len = 3'd4;
        for (int i = 0; i < 6; i++) begin
            v = 1'b1; din = 8'(i + 1); step();
        end
        v = 1'b0;
        check("pre_reset_v_o", vo0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_v_o",   vo0,    1'b0);
        check("async_v_o_msb", vo1,  1'b0);
        check("async_ready", ready0, 1'b0);
        check("async_len_o", leno0,  3'd0);
        q.delete(); part.delete(); rdy_en = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        check("post_reset_ready", ready0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            v = 1'b1; len = 3'd4; din = 8'h55 + 8'(i * 8'h11); step();
        end
        v = 1'b0;
        check("post_reset_lsb", dout0, 32'h88776655);
        check("post_reset_msb", dout1, 32'h55667788);
        check("post_reset_len", leno0, 3'd4);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
